// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: holds IF/ID until every ID-stage operand can be forwarded
// from the load in EX or the in-flight mult/div, and counts stall cycles.
module hazard_stall_unit #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_rd,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             flush,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [4:0]       md_done_rd,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] LAT = MULDIV_LAT[3:0];

    logic             r_ex_load_valid;
    logic [4:0]       r_ex_load_rd;
    logic             r_md_busy;
    logic [3:0]       r_md_cnt;
    logic [4:0]       r_md_rd;
    logic             r_md_done;
    logic [4:0]       r_md_done_rd;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_lu;
    logic w_md_raw;
    logic w_md_str;
    logic w_md_waw;
    logic w_stall;
    logic w_issue;

    // ex_load_valid is only ever set for rd!=0, so $0 never matches a load.
    assign w_lu = r_ex_load_valid &
                  ((id_uses_rs & (id_rs == r_ex_load_rd)) |
                   (id_uses_rt & (id_rt == r_ex_load_rd)));

    assign w_md_raw = r_md_busy & (r_md_rd != 5'd0) &
                      ((id_uses_rs & (id_rs == r_md_rd)) |
                       (id_uses_rt & (id_rt == r_md_rd)));

    assign w_md_str = r_md_busy & id_is_muldiv;

    assign w_md_waw = r_md_busy & id_reg_write & (id_rd != 5'd0) & (id_rd == r_md_rd);

    assign w_stall = id_valid & ~flush & (w_lu | w_md_raw | w_md_str | w_md_waw);
    assign w_issue = id_valid & ~w_stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_load_valid <= 1'b0;
            r_ex_load_rd    <= 5'd0;
            r_md_busy       <= 1'b0;
            r_md_cnt        <= 4'd0;
            r_md_rd         <= 5'd0;
            r_md_done       <= 1'b0;
            r_md_done_rd    <= 5'd0;
            r_stall_cycles  <= '0;
        end else begin
            r_ex_load_valid <= w_issue & id_is_load & id_reg_write & (id_rd != 5'd0);
            r_ex_load_rd    <= id_rd;
            r_md_done       <= 1'b0;

            // A new mult/div can only issue while idle, since md_str stalls it otherwise.
            if (w_issue & id_is_muldiv) begin
                r_md_busy <= 1'b1;
                r_md_cnt  <= LAT;
                r_md_rd   <= id_reg_write ? id_rd : 5'd0;
            end else if (r_md_busy) begin
                r_md_cnt <= r_md_cnt - 4'd1;
                if (r_md_cnt == 4'd1) begin
                    r_md_busy    <= 1'b0;
                    r_md_done    <= 1'b1;
                    r_md_done_rd <= r_md_rd;
                end
            end

            if (w_stall && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign stall        = w_stall;
    assign md_busy      = r_md_busy;
    assign md_done      = r_md_done;
    assign md_done_rd   = r_md_done_rd;
    assign stall_cycles = r_stall_cycles;

endmodule
